// File: rtl/npc_pkg.sv
// Shared definitions for the writeback/commit slice: result selects,
// the ebreak encoding, the a0 register index and the commit FSM states.
package npc_pkg;

   localparam logic [1:0]  RFRES_ALU   = 2'b00;
   localparam logic [1:0]  RFRES_MEM   = 2'b01;
   localparam logic [1:0]  RFRES_PC4   = 2'b10;
   localparam logic [1:0]  RFRES_ZERO  = 2'b11;

   localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
   localparam logic [4:0]  REG_A0      = 5'd10;

   typedef enum logic {
      RUN    = 1'b0,
      HALTED = 1'b1
   } wb_state_t;

endpackage

// File: rtl/rf_32x64.sv
// 32-entry integer register file: one write port, three bypassed read ports
// (two for decode, one tap on a0 for the halt code), x0 hardwired to zero.
module rf_32x64 #(
   parameter int W = 64
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         we,
   input  logic [4:0]   waddr,
   input  logic [W-1:0] wdata,
   input  logic [4:0]   ra1,
   output logic [W-1:0] rd1,
   input  logic [4:0]   ra2,
   output logic [W-1:0] rd2,
   input  logic [4:0]   ra3,
   output logic [W-1:0] rd3
);

   logic [W-1:0] regs [0:31];
   logic         wr_live;

   assign wr_live = we && (waddr != 5'd0);

   // NOTE: the architectural register file must read as zero after reset, so
   // this memory is cleared in the reset branch rather than left uninitialised.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 32; i++) begin
            regs[i] <= '0;
         end
      end else if (wr_live) begin
         regs[waddr] <= wdata;
      end
   end

   // A write landing this cycle is visible to readers in the same cycle.
   assign rd1 = (ra1 == 5'd0) ? '0 : (wr_live && ra1 == waddr) ? wdata : regs[ra1];
   assign rd2 = (ra2 == 5'd0) ? '0 : (wr_live && ra2 == waddr) ? wdata : regs[ra2];
   assign rd3 = (ra3 == 5'd0) ? '0 : (wr_live && ra3 == waddr) ? wdata : regs[ra3];

endmodule

// File: rtl/wb_commit.sv
// Writeback/commit stage: result select, register file write, retire counting
// and ebreak halt. Define WB_DIFFTEST_EN to add the dt_* retire-trace outputs.
module wb_commit
   import npc_pkg::*;
#(
   parameter int                XLEN     = 64,
   parameter logic [XLEN-1:0]   RESET_PC = 64'h8000_0000
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            wb_valid,
   input  logic [XLEN-1:0] wb_pc,
   input  logic [31:0]     wb_inst,
   input  logic [XLEN-1:0] wb_alu_result,
   input  logic [1:0]      wb_sel_rfres,
   input  logic [XLEN-1:0] wb_rdata,
   input  logic            wb_rf_we,
   input  logic [4:0]      wb_rf_waddr,
   input  logic            wb_sys,
   output logic            wb_ready,
   input  logic [4:0]      rs1_addr,
   input  logic [4:0]      rs2_addr,
   output logic [XLEN-1:0] rs1_data,
   output logic [XLEN-1:0] rs2_data,
   output logic            commit_valid,
   output logic [XLEN-1:0] commit_pc,
   output logic [XLEN-1:0] instret,
   output logic            halted,
   output logic [XLEN-1:0] halt_code
`ifdef WB_DIFFTEST_EN
   ,
   output logic            dt_wen,
   output logic [4:0]      dt_waddr,
   output logic [XLEN-1:0] dt_wdata,
   output logic [31:0]     dt_inst
`endif
);

   wb_state_t       state, state_nxt;
   logic            acc;
   logic            is_ebreak;
   logic            rf_we;
   logic [XLEN-1:0] wdata;
   logic [XLEN-1:0] a0_data;

   assign is_ebreak = wb_sys && (wb_inst == INST_EBREAK);
   assign rf_we     = acc && wb_rf_we && (wb_rf_waddr != 5'd0);

   // NOTE: every signal assigned in always_comb gets a default first so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      wdata = '0;
      unique case (wb_sel_rfres)
         RFRES_ALU:  wdata = wb_alu_result;
         RFRES_MEM:  wdata = wb_rdata;
         RFRES_PC4:  wdata = wb_pc + XLEN'(4);
         RFRES_ZERO: wdata = '0;
         default:    wdata = '0;
      endcase
   end

   rf_32x64 #(.W(XLEN)) u_rf (
      .clk   (clk),
      .rst   (rst),
      .we    (rf_we),
      .waddr (wb_rf_waddr),
      .wdata (wdata),
      .ra1   (rs1_addr),
      .rd1   (rs1_data),
      .ra2   (rs2_addr),
      .rd2   (rs2_data),
      .ra3   (REG_A0),
      .rd3   (a0_data)
   );

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of process ordering.
   always_ff @(posedge clk) begin
      if (rst) state <= RUN;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         RUN:     if (acc && is_ebreak) state_nxt = HALTED;
         HALTED:  state_nxt = HALTED;
         default: state_nxt = RUN;
      endcase
   end

   always_comb begin
      wb_ready = (state == RUN);
      halted   = (state == HALTED);
      acc      = wb_valid && (state == RUN);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         commit_valid <= 1'b0;
         commit_pc    <= RESET_PC;
         instret      <= '0;
         halt_code    <= '0;
      end else begin
         commit_valid <= acc;
         if (acc) begin
            commit_pc <= wb_pc;
            instret   <= instret + XLEN'(1);
         end
         if (acc && is_ebreak) halt_code <= a0_data;
      end
   end

`ifdef WB_DIFFTEST_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         dt_wen   <= 1'b0;
         dt_waddr <= '0;
         dt_wdata <= '0;
         dt_inst  <= '0;
      end else begin
         dt_wen <= rf_we;
         if (acc) begin
            dt_waddr <= wb_rf_waddr;
            dt_wdata <= wdata;
            dt_inst  <= wb_inst;
         end
      end
   end
`endif

endmodule

// File: tb/tb_wb_commit.sv
// Self-checking bench for wb_commit: a behavioural retire model compared every
// cycle, plus directed literal checks that pin the model.
module tb_wb_commit;

   localparam logic [31:0] EBREAK = 32'h0010_0073;
   localparam logic [31:0] ECALL  = 32'h0000_0073;
   localparam logic [31:0] ADDI   = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst;
   logic        wb_valid;
   logic [63:0] wb_pc;
   logic [31:0] wb_inst;
   logic [63:0] wb_alu_result;
   logic [1:0]  wb_sel_rfres;
   logic [63:0] wb_rdata;
   logic        wb_rf_we;
   logic [4:0]  wb_rf_waddr;
   logic        wb_sys;
   logic        wb_ready;
   logic [4:0]  rs1_addr, rs2_addr;
   logic [63:0] rs1_data, rs2_data;
   logic        commit_valid;
   logic [63:0] commit_pc;
   logic [63:0] instret;
   logic        halted;
   logic [63:0] halt_code;
`ifdef WB_DIFFTEST_EN
   logic        dt_wen;
   logic [4:0]  dt_waddr;
   logic [63:0] dt_wdata;
   logic [31:0] dt_inst;
`endif

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   wb_commit dut (
      .clk           (clk),
      .rst           (rst),
      .wb_valid      (wb_valid),
      .wb_pc         (wb_pc),
      .wb_inst       (wb_inst),
      .wb_alu_result (wb_alu_result),
      .wb_sel_rfres  (wb_sel_rfres),
      .wb_rdata      (wb_rdata),
      .wb_rf_we      (wb_rf_we),
      .wb_rf_waddr   (wb_rf_waddr),
      .wb_sys        (wb_sys),
      .wb_ready      (wb_ready),
      .rs1_addr      (rs1_addr),
      .rs2_addr      (rs2_addr),
      .rs1_data      (rs1_data),
      .rs2_data      (rs2_data),
      .commit_valid  (commit_valid),
      .commit_pc     (commit_pc),
      .instret       (instret),
      .halted        (halted),
      .halt_code     (halt_code)
`ifdef WB_DIFFTEST_EN
      ,
      .dt_wen        (dt_wen),
      .dt_waddr      (dt_waddr),
      .dt_wdata      (dt_wdata),
      .dt_inst       (dt_inst)
`endif
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [63:0] m_regs [32];
   logic        m_armed = 1'b0;
   logic        m_halted, m_cv;
   logic [63:0] m_cpc, m_instret, m_hc;
   logic        m_dt_wen;
   logic [4:0]  m_dt_waddr;
   logic [63:0] m_dt_wdata;
   logic [31:0] m_dt_inst;

   function automatic logic [63:0] m_wdata();
      case (wb_sel_rfres)
         2'b00:   return wb_alu_result;
         2'b01:   return wb_rdata;
         2'b10:   return wb_pc + 64'd4;
         default: return 64'd0;
      endcase
   endfunction

   function automatic logic m_writes();
      return wb_valid && !m_halted && wb_rf_we && (wb_rf_waddr != 5'd0);
   endfunction

   function automatic logic [63:0] m_read(input logic [4:0] a);
      if (a == 5'd0) return 64'd0;
      if (m_writes() && a == wb_rf_waddr) return m_wdata();
      return m_regs[a];
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 32; i++) m_regs[i] = 64'd0;
         m_halted = 1'b0; m_cv = 1'b0; m_cpc = 64'h8000_0000;
         m_instret = 64'd0; m_hc = 64'd0; m_dt_wen = 1'b0;
         m_dt_waddr = 5'd0; m_dt_wdata = 64'd0; m_dt_inst = 32'd0;
         m_armed = 1'b1;
      end else if (wb_valid && !m_halted) begin
         m_cv = 1'b1;
         m_cpc = wb_pc;
         m_instret = m_instret + 64'd1;
         m_dt_wen = m_writes();
         m_dt_waddr = wb_rf_waddr;
         m_dt_wdata = m_wdata();
         m_dt_inst = wb_inst;
         if (wb_sys && wb_inst == EBREAK) begin
            m_hc = m_read(5'd10);
            m_halted = 1'b1;
         end
         if (m_writes()) m_regs[wb_rf_waddr] = m_wdata();
      end else begin
         m_cv = 1'b0;
         m_dt_wen = 1'b0;
      end
   end

   always @(negedge clk) begin
      if (m_armed) begin
         check("m_ready",   {63'd0, wb_ready},     {63'd0, !m_halted});
         check("m_halted",  {63'd0, halted},       {63'd0, m_halted});
         check("m_cvalid",  {63'd0, commit_valid}, {63'd0, m_cv});
         check("m_cpc",     commit_pc, m_cpc);
         check("m_instret", instret,   m_instret);
         check("m_hcode",   halt_code, m_hc);
         if (!rst) begin
            check("m_rs1", rs1_data, m_read(rs1_addr));
            check("m_rs2", rs2_data, m_read(rs2_addr));
         end
`ifdef WB_DIFFTEST_EN
         check("m_dt_wen", {63'd0, dt_wen}, {63'd0, m_dt_wen});
         if (m_dt_wen) begin
            check("m_dt_waddr", {59'd0, dt_waddr}, {59'd0, m_dt_waddr});
            check("m_dt_wdata", dt_wdata, m_dt_wdata);
            check("m_dt_inst",  {32'd0, dt_inst}, {32'd0, m_dt_inst});
         end
`endif
      end
   end

   // ---------------- stimulus ----------------
   task automatic drive(input logic [1:0] sel, input logic [63:0] alu, input logic [63:0] rdata,
                        input logic [63:0] pc, input logic we, input logic [4:0] wa,
                        input logic sys, input logic [31:0] inst);
      wb_valid = 1'b1; wb_sel_rfres = sel; wb_alu_result = alu; wb_rdata = rdata;
      wb_pc = pc; wb_rf_we = we; wb_rf_waddr = wa; wb_sys = sys; wb_inst = inst;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      wb_valid = 1'b0; wb_rf_we = 1'b0; wb_sys = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      wb_valid = 1'b0; wb_pc = '0; wb_inst = '0; wb_alu_result = '0; wb_sel_rfres = '0;
      wb_rdata = '0; wb_rf_we = 1'b0; wb_rf_waddr = '0; wb_sys = 1'b0;
      rs1_addr = '0; rs2_addr = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      for (int i = 0; i < 32; i++) begin
         rs1_addr = 5'(i); rs2_addr = 5'(31 - i);
         #1;
         check("reset_rs1", rs1_data, 64'd0);
         check("reset_rs2", rs2_data, 64'd0);
      end
      check("reset_pc",      commit_pc, 64'h8000_0000);
      check("reset_instret", instret, 64'd0);
      check("reset_ready",   {63'd0, wb_ready}, 64'd1);
      check("reset_cvalid",  {63'd0, commit_valid}, 64'd0);
      tick();

      drive(2'b00, 64'h1234, 0, 64'h8000_0000, 1, 5'd5, 0, ADDI);
      rs1_addr = 5'd5; rs2_addr = 5'd5;
      #1 check("bypass_rs1", rs1_data, 64'h1234);
      check("bypass_rs2", rs2_data, 64'h1234);
      tick();
      check("addi_cvalid",  {63'd0, commit_valid}, 64'd1);
      check("addi_instret", instret, 64'd1);
      check("addi_cpc",     commit_pc, 64'h8000_0000);
      check("addi_stored",  rs1_data, 64'h1234);

      drive(2'b00, 64'hFFFF, 0, 64'h8000_0004, 1, 5'd0, 0, ADDI);
      rs1_addr = 5'd0;
      #1 check("x0_bypass", rs1_data, 64'd0);
      tick();
      check("x0_read",    rs1_data, 64'd0);
      check("x0_instret", instret, 64'd2);

      drive(2'b00, 64'h77, 0, 64'h8000_0008, 1, 5'd4, 0, ADDI); tick();
      drive(2'b11, 64'h55, 64'h66, 64'h8000_000C, 1, 5'd4, 0, ADDI);
      rs1_addr = 5'd4;
      #1 check("sel11_bypass", rs1_data, 64'd0);
      tick();
      check("sel11_stored", rs1_data, 64'd0);

      drive(2'b10, 0, 0, 64'h8000_0010, 1, 5'd1, 0, 32'h0000_006F); tick();
      drive(2'b01, 0, 64'hDEAD, 64'h8000_0014, 1, 5'd2, 0, 32'h0000_3103); tick();
      rs1_addr = 5'd1; rs2_addr = 5'd2;
      #1 check("jal_x1",  rs1_data, 64'h8000_0014);
      check("load_x2", rs2_data, 64'hDEAD);
      check("load_cpc", commit_pc, 64'h8000_0014);

      drive(2'b10, 0, 0, 64'hFFFF_FFFF_FFFF_FFFC, 1, 5'd6, 0, 32'h0000_006F); tick();
      rs1_addr = 5'd6;
      #1 check("pc4_wrap", rs1_data, 64'd0);

      drive(2'b00, 64'h2A, 0, 64'h8000_0018, 1, 5'd10, 0, ADDI); tick();
      drive(2'b00, 0, 0, 64'h8000_001C, 0, 5'd0, 1, ECALL); tick();
      check("ecall_halted",  {63'd0, halted}, 64'd0);
      check("ecall_instret", instret, 64'd9);
      check("ecall_ready",   {63'd0, wb_ready}, 64'd1);

      drive(2'b00, 0, 0, 64'h8000_0100, 0, 5'd0, 1, EBREAK); tick();
      check("ebreak_halted",  {63'd0, halted}, 64'd1);
      check("ebreak_code",    halt_code, 64'h2A);
      check("ebreak_cvalid",  {63'd0, commit_valid}, 64'd1);
      check("ebreak_cpc",     commit_pc, 64'h8000_0100);
      check("ebreak_instret", instret, 64'd10);
      check("ebreak_ready",   {63'd0, wb_ready}, 64'd0);

      drive(2'b00, 64'h99, 0, 64'h8000_0104, 1, 5'd3, 0, ADDI);
      rs1_addr = 5'd3;
      #1 check("halt_nobypass", rs1_data, 64'd0);
      tick();
      check("halt_x3",      rs1_data, 64'd0);
      check("halt_instret", instret, 64'd10);
      check("halt_cvalid",  {63'd0, commit_valid}, 64'd0);
      check("halt_code",    halt_code, 64'h2A);
      tick();

      drive(2'b00, 64'h99, 0, 64'h8000_0108, 1, 5'd3, 0, ADDI);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      rs1_addr = 5'd3; rs2_addr = 5'd10;
      #1 check("rst_x3", rs1_data, 64'd0);
      check("rst_x10",     rs2_data, 64'd0);
      check("rst_halted",  {63'd0, halted}, 64'd0);
      check("rst_instret", instret, 64'd0);
      check("rst_hcode",   halt_code, 64'd0);
      check("rst_cpc",     commit_pc, 64'h8000_0000);
      check("rst_ready",   {63'd0, wb_ready}, 64'd1);

      drive(2'b00, 64'h55, 0, 64'h8000_0000, 1, 5'd7, 0, ADDI); tick();
      rs1_addr = 5'd7;
      #1 check("x7_read", rs1_data, 64'h55);
      check("x7_cvalid", {63'd0, commit_valid}, 64'd1);
`ifdef WB_DIFFTEST_EN
      check("dt_wen",   {63'd0, dt_wen}, 64'd1);
      check("dt_waddr", {59'd0, dt_waddr}, 64'd7);
      check("dt_wdata", dt_wdata, 64'h55);
`endif
      tick();
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
